// File: rtl/ex_muldiv_if.sv
// EX-stage handshake bundle for the RV32M multiply/divide unit: forwarded
// operand sources and controls in, stall/done/result out.
interface ex_muldiv_if #(
  parameter int WORD_BITWIDTH = 32
);
  logic                     start;
  logic [2:0]               funct3;
  logic [WORD_BITWIDTH-1:0] regReadData1;
  logic [WORD_BITWIDTH-1:0] regReadData2;
  logic [WORD_BITWIDTH-1:0] fd_ex_mem_data;
  logic [WORD_BITWIDTH-1:0] fd_mem_wb_data;
  logic [1:0]               forwardA;
  logic [1:0]               forwardB;
  logic                     flush;
  logic                     busy;
  logic                     done;
  logic [WORD_BITWIDTH-1:0] result;

  modport master (
    output start, funct3, regReadData1, regReadData2, fd_ex_mem_data,
           fd_mem_wb_data, forwardA, forwardB, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, regReadData1, regReadData2, fd_ex_mem_data,
           fd_mem_wb_data, forwardA, forwardB, flush,
    output busy, done, result
  );
endinterface

// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M execute unit: shift-add multiply (MUL_UNROLL bits/cycle)
// and restoring divide on operand magnitudes, sign fixed up on retirement.
module ex_muldiv #(
  parameter int WORD_BITWIDTH = 32,
  parameter int MUL_UNROLL    = 1
) (
  input  logic        clk,
  input  logic        rst,
  ex_muldiv_if.slave  bus
);
  localparam int W     = WORD_BITWIDTH;
  localparam int CW    = $clog2(W) + 1;
  localparam int MUL_N = W / MUL_UNROLL;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [2:0]       op;
  logic             neg_q, neg_r;
  logic [W-1:0]     opb;
  logic [2*W-1:0]   mcand, acc;
  logic [W-1:0]     result_q;
  logic             busy_c, done_c;

  function automatic logic [W-1:0] fwd_sel(input logic [1:0] sel, input logic [W-1:0] rf,
                                           input logic [W-1:0] memwb, input logic [W-1:0] exmem);
    case (sel)
      2'b00:   return rf;
      2'b01:   return memwb;
      2'b10:   return exmem;
      default: return W'(32'hDEADBEEF);
    endcase
  endfunction

  function automatic logic [W-1:0] mul_fix(input logic [2*W-1:0] prod, input logic neg,
                                           input logic [2:0] f);
    logic [2*W-1:0] full;
    full = neg ? -prod : prod;
    return (f[1:0] == 2'b00) ? full[W-1:0] : full[2*W-1:W];
  endfunction

  function automatic logic [W-1:0] div_fix(input logic [2*W-1:0] qr, input logic nq,
                                           input logic nr, input logic [2:0] f);
    logic [W-1:0] q, r;
    q = qr[W-1:0];
    r = qr[2*W-1:W];
    return f[1] ? (nr ? -r : r) : (nq ? -q : q);
  endfunction

  // Accept-cycle operand capture, signedness and divide special cases
  logic [W-1:0] a_in, b_in, a_mag, b_mag, special_res;
  logic         sgn_a, sgn_b, a_neg, b_neg, div_zero, div_ovf, special, accept;

  always_comb begin
    a_in     = fwd_sel(bus.forwardA, bus.regReadData1, bus.fd_mem_wb_data, bus.fd_ex_mem_data);
    b_in     = fwd_sel(bus.forwardB, bus.regReadData2, bus.fd_mem_wb_data, bus.fd_ex_mem_data);
    sgn_a    = bus.funct3[2] ? ~bus.funct3[0] : ~(bus.funct3[1] & bus.funct3[0]);
    sgn_b    = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
    a_neg    = sgn_a & a_in[W-1];
    b_neg    = sgn_b & b_in[W-1];
    a_mag    = a_neg ? -a_in : a_in;
    b_mag    = b_neg ? -b_in : b_in;
    div_zero = bus.funct3[2] & (b_in == '0);
    div_ovf  = bus.funct3[2] & ~bus.funct3[0] & (a_in == {1'b1, {(W-1){1'b0}}}) & (b_in == '1);
    special  = div_zero | div_ovf;
    if (div_zero) special_res = bus.funct3[1] ? a_in : '1;
    else          special_res = bus.funct3[1] ? '0 : a_in;
    accept   = (state == IDLE) & bus.start & ~bus.flush;
  end

  // One iteration step for each engine
  logic [2*W-1:0] acc_mul, acc_div;
  logic [W:0]     shifted, diffw;
  logic           ge, last;

  always_comb begin
    acc_mul = acc;
    for (int i = 0; i < MUL_UNROLL; i++)
      if (opb[i]) acc_mul = acc_mul + (mcand << i);
    shifted = {acc[2*W-1:W], acc[W-1]};
    diffw   = shifted - {1'b0, opb};
    ge      = shifted >= {1'b0, opb};
    acc_div = {(ge ? diffw[W-1:0] : shifted[W-1:0]), acc[W-2:0], ge};
    last    = (cnt == CW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy_c   = 1'b0;
    done_c   = 1'b0;
    case (state)
      IDLE: if (accept) begin
        busy_c   = 1'b1;
        state_nx = special ? DONE : (bus.funct3[2] ? DIV : MUL);
      end
      MUL, DIV: begin
        busy_c = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done_c   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (bus.flush) begin
      state_nx = IDLE;
      done_c   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      result_q <= '0;
    end else if (bus.flush) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op    <= bus.funct3;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          opb   <= b_mag;
          if (special) begin
            result_q <= special_res;
            cnt      <= '0;
          end else if (bus.funct3[2]) begin
            acc <= {{W{1'b0}}, a_mag};
            cnt <= CW'(W);
          end else begin
            acc   <= '0;
            mcand <= {{W{1'b0}}, a_mag};
            cnt   <= CW'(MUL_N);
          end
        end
        MUL: begin
          acc   <= acc_mul;
          mcand <= mcand << MUL_UNROLL;
          opb   <= opb >> MUL_UNROLL;
          cnt   <= cnt - CW'(1);
          if (last) result_q <= mul_fix(acc_mul, neg_q, op);
        end
        DIV: begin
          acc <= acc_div;
          cnt <= cnt - CW'(1);
          if (last) result_q <= div_fix(acc_div, neg_q, neg_r, op);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = busy_c;
  assign bus.done   = done_c;
  assign bus.result = result_q;
endmodule
